nano_gpio_irq: RTL and testbench

//  Parametrised Wishbone GPIO slave for the DE0-Nano debug board: LED output register,

---
 rtl/nano_gpio_pkg.sv | 18 +
 rtl/nano_pb_debounce.sv | 50 +++++
 rtl/nano_gpio_irq.sv | 143 ++++++++++++++
 tb/tb_nano_gpio_irq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_gpio_pkg.sv
// nano_gpio_pkg
//   Shared definitions for the DE0-Nano GPIO/interrupt Wishbone slave.
//   Holds the register address map used by the bus decoder and by any
//   software-facing collateral that needs the same numbering.
package nano_gpio_pkg;

    // Wishbone data bus width of the Zet I/O bus
    localparam int GPIO_DW = 16;

    // Word addresses of the four registers
    typedef enum logic [1:0] {
        GPIO_SW    = 2'd0,   // switch inputs, read-only
        GPIO_LEDS  = 2'd1,   // LED output register, byte-lane writable
        GPIO_PBCTL = 2'd2,   // [15:8] irq enable, [7:0] debounced button levels
        GPIO_PEND  = 2'd3    // pending press interrupts, write-1-to-clear
    } gpio_reg_e;

endpackage

// File: rtl/nano_pb_debounce.sv
// nano_pb_debounce
//   One pushbutton: two-flop synchroniser on the inverted (pressed-high)
//   button input, then an immediate-change / hold-off debouncer. A change of
//   the synchronised level is taken at once and starts a hold-off of
//   2**DB_W-1 tick pulses during which further changes are ignored.
// Ports
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   tick1  in  single-cycle debounce timebase pulse (already synchronised)
//   pb_n   in  raw active-low button (asynchronous)
//   level  out debounced pressed level (1 = pressed)
module nano_pb_debounce #(
    parameter int DB_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick1,
    input  logic pb_n,
    output logic level
);

    localparam logic [DB_W-1:0] CNT_MAX = '1;

    logic [1:0]      press_sync;
    logic [DB_W-1:0] cnt;

    // The synchroniser carries the pressed sense (inverted button), so its
    // cleared reset state means "released" and no false press follows reset.
    // A counter at its maximum means the hold-off has expired and the next
    // level difference is accepted immediately; otherwise tick pulses count
    // it back up, and it naturally stops at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_sync <= '0;
            level      <= 1'b0;
            cnt        <= CNT_MAX;
        end else begin
            press_sync <= {press_sync[0], ~pb_n};
            if (cnt == CNT_MAX) begin
                if (press_sync[1] != level) begin
                    level <= press_sync[1];
                    cnt   <= '0;
                end
            end else if (tick1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nano_gpio_irq.sv
// nano_gpio_irq
//   Wishbone GPIO slave for the DE0-Nano debug board: LED register,
//   synchronised switches, debounced active-low pushbuttons with per-button
//   press-interrupt latching, enable mask, W1C pending register and irq_o.
//   Button 0's debounced level is also exported as nmi_pb.
// Ports
//   wb_clk_i/wb_rst_i      clock, synchronous active-high reset
//   wb_adr_i..wb_cyc_i     Wishbone slave inputs (word address, 16-bit data)
//   wb_dat_o/wb_ack_o      registered read data and acknowledge
//   leds_                  LED drive
//   sw_/pb_/tick           asynchronous switch, button and timebase inputs
//   nmi_pb                 debounced pressed level of button 0
//   irq_o                  registered |(pending & irq_en)
module nano_gpio_irq
    import nano_gpio_pkg::*;
#(
    parameter int NLEDS = 16,
    parameter int NSW   = 8,
    parameter int NPB   = 4,
    parameter int DB_W  = 3
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [1:0]         wb_adr_i,
    input  logic [15:0]        wb_dat_i,
    output logic [15:0]        wb_dat_o,
    input  logic [1:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    output logic [NLEDS-1:0]   leds_,
    input  logic [NSW-1:0]     sw_,
    input  logic [NPB-1:0]     pb_,
    input  logic               tick,
    output logic               nmi_pb,
    output logic               irq_o
);

    logic [NSW-1:0]     sw_meta, sw_sync;
    logic [2:0]         tick_sync;
    logic               tick1;
    logic [NPB-1:0]     pb_level, pb_level_d, pb_rise;
    logic [NPB-1:0]     irq_en, pending, pend_clr;
    logic [GPIO_DW-1:0] rd_data;
    logic               bus_op, bus_wr;
    logic               unused_dat;

    // Only some write-data bits reach a register for narrow parameter sets
    assign unused_dat = ^wb_dat_i;

    // Switch and timebase synchronisers; the third tick flop gives the
    // previous synced value so tick1 is a one-cycle rising-edge pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            tick_sync <= '0;
        end else begin
            sw_meta   <= sw_;
            sw_sync   <= sw_meta;
            tick_sync <= {tick_sync[1:0], tick};
        end
    end

    assign tick1 = tick_sync[1] & ~tick_sync[2];

    for (genvar g = 0; g < NPB; g++) begin : g_pb
        nano_pb_debounce #(
            .DB_W (DB_W)
        ) u_debounce (
            .clk   (wb_clk_i),
            .rst   (wb_rst_i),
            .tick1 (tick1),
            .pb_n  (pb_[g]),
            .level (pb_level[g])
        );
    end

    assign nmi_pb  = pb_level[0];
    assign pb_rise = pb_level & ~pb_level_d;

    // A transfer is serviced only while ack is low, so a held strobe is
    // acknowledged every second cycle and each access happens exactly once.
    assign bus_op   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign bus_wr   = bus_op & wb_we_i;
    assign pend_clr = (bus_wr && wb_adr_i == GPIO_PEND && wb_sel_i[0])
                      ? wb_dat_i[NPB-1:0] : '0;

    // Read multiplexer; anything not backed by a register reads as zero
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            GPIO_SW:    rd_data[NSW-1:0] = sw_sync;
            GPIO_LEDS:  rd_data[NLEDS-1:0] = leds_;
            GPIO_PBCTL: begin
                rd_data[8 +: NPB]  = irq_en;
                rd_data[NPB-1:0]   = pb_level;
            end
            GPIO_PEND:  rd_data[NPB-1:0] = pending;
        endcase
    end

    // Bus handshake and registered read data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_op;
            if (bus_op) begin
                wb_dat_o <= rd_data;
            end
        end
    end

    // Writable registers and interrupt state. A press arriving in the same
    // cycle as a clear of that bit wins, so no press is ever lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            leds_      <= '0;
            irq_en     <= '0;
            pending    <= '0;
            pb_level_d <= '0;
            irq_o      <= 1'b0;
        end else begin
            if (bus_wr && wb_adr_i == GPIO_LEDS) begin
                for (int i = 0; i < NLEDS; i++) begin
                    if (wb_sel_i[i/8]) begin
                        leds_[i] <= wb_dat_i[i];
                    end
                end
            end
            if (bus_wr && wb_adr_i == GPIO_PBCTL && wb_sel_i[1]) begin
                irq_en <= wb_dat_i[8 +: NPB];
            end
            pb_level_d <= pb_level;
            pending    <= (pending & ~pend_clr) | pb_rise;
            irq_o      <= |(pending & irq_en);
        end
    end

endmodule

// File: tb/tb_nano_gpio_irq.sv
// tb_nano_gpio_irq
//   Directed self-checking bench for nano_gpio_irq with default parameters
//   (16 LEDs, 8 switches, 4 buttons, 3-bit debounce counter).
module tb_nano_gpio_irq;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [1:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [15:0] leds_;
    logic [7:0]  sw_  = 8'hA5;
    logic [3:0]  pb_  = 4'hF;
    logic        tick = 1'b0;
    logic        nmi_pb;
    logic        irq_o;

    int vectors     = 0;
    int miscompares = 0;

    nano_gpio_irq dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .leds_    (leds_),
        .sw_      (sw_),
        .pb_      (pb_),
        .tick     (tick),
        .nmi_pb   (nmi_pb),
        .irq_o    (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // One bus transfer: drive at a falling edge, wait (bounded) for ack,
    // capture read data 1ns after the acking edge, then release the bus.
    task automatic bus_xfer(input logic [1:0] adr, input logic we, input logic [1:0] sel,
                            input logic [15:0] dat, output logic [15:0] rdata);
        bit got;
        got   = 0;
        rdata = 16'hDEAD;
        @(negedge wb_clk_i);
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge wb_clk_i);
            #1;
            if (wb_ack_o) begin
                got   = 1;
                rdata = wb_dat_o;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("[TB] FAIL ack_timeout adr=%0d got no ack, required ack within 8 cycles", adr);
        end
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // n debounce tick pulses, each long enough for the synchroniser to see
    task automatic pulse_tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge wb_clk_i);
            tick = 1'b1;
            @(negedge wb_clk_i);
            tick = 1'b0;
            repeat (3) @(negedge wb_clk_i);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        vectors += 5;
        if (leds_ !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_leds got %h want 0000", leds_); end
        if (wb_ack_o !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_ack got %b want 0", wb_ack_o); end
        if (wb_dat_o !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_dat got %h want 0000", wb_dat_o); end
        if (nmi_pb !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_nmi got %b want 0", nmi_pb); end
        if (irq_o !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_irq got %b want 0", irq_o); end
    endtask

    task automatic test_sw_read();
        logic [15:0] rd;
        repeat (3) @(posedge wb_clk_i);
        bus_xfer(2'd0, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h00A5) begin miscompares++; $display("[TB] FAIL sw_read_a5 got %h want 00A5", rd); end
        bus_xfer(2'd1, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL leds_read_reset got %h want 0000", rd); end
        sw_ = 8'h3C;
        repeat (3) @(posedge wb_clk_i);
        bus_xfer(2'd0, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h003C) begin miscompares++; $display("[TB] FAIL sw_read_3c got %h want 003C", rd); end
    endtask

    task automatic test_leds();
        logic [15:0] rd;
        bus_xfer(2'd1, 1'b1, 2'b01, 16'h1234, rd);
        vectors++;
        if (leds_ !== 16'h0034) begin miscompares++; $display("[TB] FAIL leds_lane0 got %h want 0034", leds_); end
        bus_xfer(2'd1, 1'b1, 2'b10, 16'hAB00, rd);
        vectors++;
        if (leds_ !== 16'hAB34) begin miscompares++; $display("[TB] FAIL leds_lane1 got %h want AB34", leds_); end
        bus_xfer(2'd1, 1'b1, 2'b00, 16'hFFFF, rd);
        bus_xfer(2'd0, 1'b1, 2'b11, 16'hFFFF, rd);
        vectors++;
        if (leds_ !== 16'hAB34) begin miscompares++; $display("[TB] FAIL leds_no_lane_or_adr0 got %h want AB34", leds_); end
        bus_xfer(2'd1, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'hAB34) begin miscompares++; $display("[TB] FAIL leds_readback got %h want AB34", rd); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack;
        exp_ack = 4'b0101;
        @(negedge wb_clk_i);
        wb_adr_i = 2'd1;
        wb_we_i  = 1'b0;
        wb_sel_i = 2'b11;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge wb_clk_i);
            #1;
            vectors++;
            if (wb_ack_o !== exp_ack[k]) begin
                miscompares++;
                $display("[TB] FAIL b2b_ack[%0d] got %b want %b", k, wb_ack_o, exp_ack[k]);
            end
        end
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        vectors++;
        if (wb_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ack_idle got %b want 0", wb_ack_o); end
    endtask

    task automatic test_debounce();
        @(negedge wb_clk_i);
        pb_[0] = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (nmi_pb !== 1'b0) begin miscompares++; $display("[TB] FAIL nmi_early got %b want 0", nmi_pb); end
        @(posedge wb_clk_i);
        #1;
        vectors++;
        if (nmi_pb !== 1'b1) begin miscompares++; $display("[TB] FAIL nmi_press got %b want 1", nmi_pb); end
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        pb_[0] = 1'b1;
        pulse_tick(2);
        vectors++;
        if (nmi_pb !== 1'b1) begin miscompares++; $display("[TB] FAIL nmi_bounce got %b want 1", nmi_pb); end
        pulse_tick(4);
        vectors++;
        if (nmi_pb !== 1'b1) begin miscompares++; $display("[TB] FAIL nmi_holdoff6 got %b want 1", nmi_pb); end
        pulse_tick(1);
        vectors++;
        if (nmi_pb !== 1'b0) begin miscompares++; $display("[TB] FAIL nmi_release got %b want 0", nmi_pb); end
    endtask

    task automatic test_irq();
        logic [15:0] rd;
        bus_xfer(2'd3, 1'b1, 2'b01, 16'h000F, rd);
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL pend_clear_all got %h want 0000", rd); end
        @(negedge wb_clk_i);
        pb_[2] = 1'b0;
        repeat (6) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (irq_o !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_masked got %b want 0", irq_o); end
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0004) begin miscompares++; $display("[TB] FAIL pend_press2 got %h want 0004", rd); end
        bus_xfer(2'd2, 1'b1, 2'b10, 16'h0400, rd);
        vectors++;
        if (irq_o !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_latency got %b want 0", irq_o); end
        @(posedge wb_clk_i);
        #1;
        vectors++;
        if (irq_o !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_enabled got %b want 1", irq_o); end
        bus_xfer(2'd2, 1'b1, 2'b10, 16'hF400, rd);
        bus_xfer(2'd2, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0404) begin miscompares++; $display("[TB] FAIL pbctl_read got %h want 0404", rd); end
        bus_xfer(2'd3, 1'b1, 2'b10, 16'h0004, rd);
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0004) begin miscompares++; $display("[TB] FAIL pend_lane1_noclr got %h want 0004", rd); end
        bus_xfer(2'd3, 1'b1, 2'b01, 16'h0004, rd);
        @(posedge wb_clk_i);
        #1;
        vectors++;
        if (irq_o !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_after_w1c got %b want 0", irq_o); end
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL pend_w1c got %h want 0000", rd); end
    endtask

    task automatic test_set_beats_clear();
        logic [15:0] rd;
        @(negedge wb_clk_i);
        pb_ = 4'b1101;
        repeat (5) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        pb_ = 4'b1111;
        pulse_tick(16);
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0002) begin miscompares++; $display("[TB] FAIL pend_press1 got %h want 0002", rd); end
        bus_xfer(2'd2, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0400) begin miscompares++; $display("[TB] FAIL levels_released got %h want 0400", rd); end
        // Press lands on the third edge; the clear is acked on the fourth,
        // the same edge that latches the new press.
        @(negedge wb_clk_i);
        pb_[1] = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        bus_xfer(2'd3, 1'b1, 2'b01, 16'h0002, rd);
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0002) begin miscompares++; $display("[TB] FAIL set_beats_clear got %h want 0002", rd); end
        bus_xfer(2'd3, 1'b1, 2'b01, 16'h0002, rd);
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL pend_clear1 got %h want 0000", rd); end
        @(negedge wb_clk_i);
        pb_[1] = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        @(negedge wb_clk_i);
        pb_[3] = 1'b0;
        repeat (5) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_adr_i = 2'd1;
        wb_we_i  = 1'b1;
        wb_sel_i = 2'b11;
        wb_dat_i = 16'h5555;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        pb_[3]   = 1'b1;
        @(posedge wb_clk_i);
        #1;
        vectors += 3;
        if (wb_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ack got %b want 0", wb_ack_o); end
        if (leds_ !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_mid_leds got %h want 0000", leds_); end
        if (irq_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_mid_irq got %b want 0", irq_o); end
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_rst_i = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        bus_xfer(2'd2, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_mid_pbctl got %h want 0000", rd); end
        bus_xfer(2'd3, 1'b0, 2'b11, 16'h0, rd);
        vectors++;
        if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_mid_pend got %h want 0000", rd); end
    endtask

    initial begin
        $display("[TB] nano_gpio_irq directed bench start");
        test_reset();
        test_sw_read();
        test_leds();
        test_back_to_back();
        test_debounce();
        test_irq();
        test_set_beats_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
